mem_rr_sched: RTL
=================

# mem_rr_sched

Round-robin scheduler that shares the single memory/data port (DRAM + MMIO data path) between two cores. Each core posts a one-cycle load or store strobe, which the scheduler latches in a per-core pending slot. The scheduler then issues one transaction at a time to the shared port and follows the port's busy rise/fall handshake. When the transaction finishes, it returns read data and releases that core's busy flag. The block sits between the two core bus interfaces and the memory-side mux in the SoC top.

## Interface
- TIMEOUT_W, 8, width of the issue watchdog counter; timeout fires after 2^TIMEOUT_W-1 cycles.
- CLK  in  1  system clock, all logic on posedge.
- RST_X  in  1  asynchronous active-low reset.
- req_le0, req_le1  in  1  one-cycle load strobe from core 0/1.
- req_we0, req_we1  in  1  one-cycle store strobe from core 0/1.
- req_addr0, req_addr1  in  32  physical address; sampled with the strobe.
- req_wdata0, req_wdata1  in  32  store data; sampled with the strobe.
- req_busy0, req_busy1  out  1  core's request is pending or in flight.
- rdata0, rdata1  out  32  last load result for the core; holds until its next load completes.
- mem_addr  out  32  address driven to the shared port.
- mem_wdata  out  32  store data driven to the shared port.
- mem_le  out  1  load strobe to the shared port.
- mem_we  out  1  store strobe to the shared port.
- mem_rdata  in  32  load data from the shared port; valid when mem_busy falls.
- mem_busy  in  1  shared port busy (dram busy OR data busy OR !tx_ready).
- grant  out  1  core owning the current or last transaction.
- err  out  1  one-cycle pulse when a transaction times out.

## Operation
- Pending slots, one per core. A strobe with req_busyN=0 latches op, addr and wdata, and sets req_busyN.
  - A strobe with req_busyN=1 is ignored.
  - If le and we are both high in the same cycle, le wins and we is dropped.
- States:
  - IDLE: if any slot is pending, select a core, drive mem_addr/mem_wdata from its slot, raise mem_le or mem_we, set grant, go to ARM.
  - ARM: hold the strobe until mem_busy=1, then drop the strobe and go to WAIT.
  - WAIT: when mem_busy=0, a load copies mem_rdata into rdataN. Clear req_busyN, record last=N, go to IDLE.
- Arbitration:
  - Only one core pending: that core wins.
  - Both cores pending: the core other than last wins.
  - last resets to 1, so core 0 wins the first tie.
- mem_addr/mem_wdata hold their value after the transaction; only the strobes return to 0.
- mem_busy=1 while in IDLE: no issue; wait in IDLE until mem_busy=0.
- Reset mid-transaction: all state clears immediately, the strobes drop, and pending requests are lost.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE, both slots empty, last=1.
- Strobe in cycle T → req_busyN=1 at T+1.
  - If the scheduler is IDLE, the slot is empty and mem_busy=0, mem_le/mem_we rise at T+2.
- mem_busy seen high at cycle A → strobe low at A+1.
- mem_busy seen low in WAIT at cycle D → rdataN valid and req_busyN=0 at D+1.
- Back-to-back: next issue from IDLE no earlier than D+2.
- A core may post a new strobe in the cycle after it sees req_busyN=0.
  - The strobe is accepted even if the other core's slot is pending.

## Configuration
- MEM_RR_SCHED_TIMEOUT_EN defined:
  - a TIMEOUT_W counter runs in ARM;
  - if mem_busy stays 0 for 2^TIMEOUT_W-1 cycles, drop the strobe, pulse err, clear req_busyN without updating rdataN, set last=N, go to IDLE.
- Not defined: ARM waits indefinitely, and err is tied to 0.

## Test plan
- Single load: core0 strobe, addr=0x80001000; port busy 3 cycles, mem_rdata=0xDEADBEEF → mem_le=1 for 1 cycle after busy rises, rdata0=0xDEADBEEF, req_busy0=0 at D+1.
- Simultaneous strobes after reset: core0 store 0x11 @0x100, core1 load @0x200 → core0 served first (grant=0), then core1 (grant=1). In a second tie, core0 wins (last=1).
- Repeated ties: both cores post 4 requests each, re-posting on release → grants strictly alternate 0,1,0,1,…
- Strobe with req_busy0=1: second strobe addr=0x300 while the first is in flight → ignored; only one mem_le issued, with the first address.
- Timeout (macro on, TIMEOUT_W=4): core1 load, mem_busy held 0 → err pulse at cycle 15 of ARM, req_busy1=0, rdata1 unchanged. Macro off: mem_le stays high for the whole 100-cycle window.
- Reset asserted in WAIT → all outputs 0 asynchronously, no rdata update after release, next tie goes to core 0.

Source files
------------

// File: rtl/mem_rr_sched.sv
// Round-robin scheduler sharing one memory/data port between two cores (optional watchdog: MEM_RR_SCHED_TIMEOUT_EN).
// Latency: strobe -> busy +1, issue +2; port busy fall -> rdata/busy release +1. Backpressure: busy strobes are dropped.
// Backpressure: the port's busy signal holds the scheduler in IDLE/ARM/WAIT.
module mem_rr_sched #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        req_le0,
    input  logic        req_le1,
    input  logic        req_we0,
    input  logic        req_we1,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic        req_busy0,
    output logic        req_busy1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_le,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic        grant,
    output logic        err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARM = 2'd1, S_WAIT = 2'd2} state_t;

    if (TIMEOUT_W < 2) begin : g_bad_cfg
        $error("TIMEOUT_W must be at least 2");
    end

    state_t      r_state, w_next;
    logic [1:0]  r_pend, r_ld;
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [31:0] r_rdata [2];
    logic        r_last, r_grant, r_le, r_we;
    logic [31:0] r_maddr, r_mwdata;

    logic [1:0]  w_le, w_we, w_acc;
    logic [31:0] w_addr  [2];
    logic [31:0] w_wdata [2];
    logic        w_sel, w_issue, w_drop, w_done, w_abort, w_release;

`ifdef MEM_RR_SCHED_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] r_tmo;
    logic                 r_err;
`endif

    assign w_le      = {req_le1, req_le0};
    assign w_we      = {req_we1, req_we0};
    assign w_addr[0] = req_addr0;
    assign w_addr[1] = req_addr1;
    assign w_wdata[0] = req_wdata0;
    assign w_wdata[1] = req_wdata1;
    assign w_acc     = (w_le | w_we) & ~r_pend;
    // A tie goes to the core that did not own the previous transaction.
    assign w_sel     = (&r_pend) ? ~r_last : r_pend[1];
    assign w_release = w_done | w_abort;

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_drop  = 1'b0;
        w_done  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!mem_busy && (|r_pend)) begin
                    w_issue = 1'b1;
                    w_next  = S_ARM;
                end
            end
            S_ARM: begin
                if (mem_busy) begin
                    w_drop = 1'b1;
                    w_next = S_WAIT;
                end
`ifdef MEM_RR_SCHED_TIMEOUT_EN
                else if (r_tmo == TMO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
`endif
            end
            S_WAIT: begin
                if (!mem_busy) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_pend <= '0;
            r_ld   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_rdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_acc[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_ld[i]    <= w_le[i];
                    r_addr[i]  <= w_addr[i];
                    r_wdata[i] <= w_wdata[i];
                end else if (w_release && r_grant == 1'(i)) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_done && r_ld[i] && r_grant == 1'(i)) r_rdata[i] <= mem_rdata;
            end
        end
    end

    // Address/data stay on the port after a transaction; only the strobes return to 0.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_le     <= 1'b0;
            r_we     <= 1'b0;
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            if (w_issue) begin
                r_maddr  <= r_addr[w_sel];
                r_mwdata <= r_wdata[w_sel];
                r_le     <= r_ld[w_sel];
                r_we     <= ~r_ld[w_sel];
                r_grant  <= w_sel;
            end else if (w_drop || w_abort) begin
                r_le <= 1'b0;
                r_we <= 1'b0;
            end
            if (w_release) r_last <= r_grant;
        end
    end

`ifdef MEM_RR_SCHED_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
            if (r_state != S_ARM) r_tmo <= '0;
            else                  r_tmo <= r_tmo + 1'b1;
        end
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign req_busy0 = r_pend[0];
    assign req_busy1 = r_pend[1];
    assign rdata0    = r_rdata[0];
    assign rdata1    = r_rdata[1];
    assign mem_addr  = r_maddr;
    assign mem_wdata = r_mwdata;
    assign mem_le    = r_le;
    assign mem_we    = r_we;
    assign grant     = r_grant;
endmodule
